// File: rtl/pcpi_hub_if.sv
// PCPI hub bus bundle: core-facing request/response plus the broadcast/collect slave side.
// pcpi_conflict exists only when PCPI_HUB_CONFLICT_CHK_EN is defined.
interface pcpi_hub_if #(
   parameter int NUM_SLAVES = 2
);
   logic                    pcpi_valid;
   logic [31:0]             pcpi_insn;
   logic [31:0]             pcpi_rs1;
   logic [31:0]             pcpi_rs2;
   logic                    pcpi_wr;
   logic [31:0]             pcpi_rd;
   logic                    pcpi_wait;
   logic                    pcpi_ready;
   logic                    pcpi_timeout;
`ifdef PCPI_HUB_CONFLICT_CHK_EN
   logic                    pcpi_conflict;
`endif
   logic                    s_valid;
   logic [31:0]             s_insn;
   logic [31:0]             s_rs1;
   logic [31:0]             s_rs2;
   logic [NUM_SLAVES-1:0]   s_wr;
   logic [32*NUM_SLAVES-1:0] s_rd;
   logic [NUM_SLAVES-1:0]   s_wait;
   logic [NUM_SLAVES-1:0]   s_ready;

   // Hub view: takes core requests and slave responses, drives everything else.
   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  s_wr, s_rd, s_wait, s_ready,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
`ifdef PCPI_HUB_CONFLICT_CHK_EN
      output pcpi_conflict,
`endif
      output s_valid, s_insn, s_rs1, s_rs2
   );

   // Surroundings view: the core plus the coprocessors.
   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output s_wr, s_rd, s_wait, s_ready,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
`ifdef PCPI_HUB_CONFLICT_CHK_EN
      input  pcpi_conflict,
`endif
      input  s_valid, s_insn, s_rs1, s_rs2
   );
endinterface

// File: rtl/pcpi_hub.sv
// PCPI fan-out hub: latches a core request, broadcasts it, returns the lowest-index ready result.
// Optional PCPI_HUB_CONFLICT_CHK_EN adds pcpi_conflict for multi-slave claims.
module pcpi_hub #(
   parameter int NUM_SLAVES     = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic          clk,
   input logic          resetn,
   pcpi_hub_if.slave    bus
);
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DISPATCH = 3'd1,
      ST_BUSY     = 3'd2,
      ST_RESPOND  = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_s_valid;
   logic        r_wait;
   logic        r_ready;
   logic        r_wr;
   logic        r_timeout;
   logic [31:0] r_rd;
   logic [31:0] r_insn;
   logic [31:0] r_rs1;
   logic [31:0] r_rs2;
   logic [31:0] w_rd;
   logic        w_wr;
   logic        w_any_ready;
   logic        w_any_wait;
   logic        w_capture;

   assign w_any_ready = |bus.s_ready;
   assign w_any_wait  = |bus.s_wait;
   assign w_capture   = ((r_state == ST_DISPATCH) || (r_state == ST_BUSY)) && w_any_ready;

   // Lowest-index ready slave wins: scan from the top so lower indices overwrite.
   always_comb begin
      w_rd = 32'd0;
      w_wr = 1'b0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         w_rd = bus.s_ready[i] ? bus.s_rd[32*i +: 32] : w_rd;
         w_wr = bus.s_ready[i] ? bus.s_wr[i] : w_wr;
      end
   end

   // Request sequencer with all core/slave-facing outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 8'd0;
         r_s_valid <= 1'b0;
         r_wait    <= 1'b0;
         r_ready   <= 1'b0;
         r_wr      <= 1'b0;
         r_timeout <= 1'b0;
         r_rd      <= 32'd0;
         r_insn    <= 32'd0;
         r_rs1     <= 32'd0;
         r_rs2     <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.pcpi_valid) begin
                  r_insn    <= bus.pcpi_insn;
                  r_rs1     <= bus.pcpi_rs1;
                  r_rs2     <= bus.pcpi_rs2;
                  r_cnt     <= 8'd0;
                  r_s_valid <= 1'b1;
                  r_state   <= ST_DISPATCH;
               end else begin
                  r_state   <= ST_IDLE;
               end
            end
            ST_DISPATCH: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_capture) begin
                  r_rd      <= w_rd;
                  r_wr      <= w_wr;
                  r_ready   <= 1'b1;
                  r_s_valid <= 1'b0;
                  r_wait    <= 1'b0;
                  r_state   <= ST_RESPOND;
               end else if (w_any_wait) begin
                  r_wait    <= 1'b1;
                  r_state   <= ST_BUSY;
               end else if (r_cnt == LP_TO_LAST) begin
                  r_timeout <= 1'b1;
                  r_s_valid <= 1'b0;
                  r_state   <= ST_GAP;
               end else begin
                  r_state   <= ST_DISPATCH;
               end
            end
            ST_BUSY: begin
               // A claimed instruction may take arbitrarily long; only s_ready moves on.
               if (w_capture) begin
                  r_rd      <= w_rd;
                  r_wr      <= w_wr;
                  r_ready   <= 1'b1;
                  r_s_valid <= 1'b0;
                  r_wait    <= 1'b0;
                  r_state   <= ST_RESPOND;
               end else begin
                  r_state   <= ST_BUSY;
               end
            end
            ST_RESPOND: begin
               r_ready <= 1'b0;
               r_wr    <= 1'b0;
               r_state <= ST_GAP;
            end
            ST_GAP: begin
               r_timeout <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.pcpi_wr      = r_wr;
   assign bus.pcpi_rd      = r_rd;
   assign bus.pcpi_wait    = r_wait;
   assign bus.pcpi_ready   = r_ready;
   assign bus.pcpi_timeout = r_timeout;
   assign bus.s_valid      = r_s_valid;
   assign bus.s_insn       = r_insn;
   assign bus.s_rs1        = r_rs1;
   assign bus.s_rs2        = r_rs2;

`ifdef PCPI_HUB_CONFLICT_CHK_EN
   logic r_conflict;
   logic r_conflict_pend;

   function automatic logic multi_hot(input logic [NUM_SLAVES-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         multi = multi | (seen & v[i]);
         seen  = seen | v[i];
      end
      return multi;
   endfunction

   // Multi-wait is remembered until the result returns, then reported alongside pcpi_ready.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_conflict      <= 1'b0;
         r_conflict_pend <= 1'b0;
      end else if (w_capture) begin
         r_conflict      <= r_conflict_pend | multi_hot(bus.s_ready);
         r_conflict_pend <= 1'b0;
      end else if ((r_state == ST_DISPATCH) && w_any_wait && multi_hot(bus.s_wait)) begin
         r_conflict_pend <= 1'b1;
      end else if (r_state == ST_RESPOND) begin
         r_conflict      <= 1'b0;
      end else begin
         r_conflict      <= r_conflict;
      end
   end

   assign bus.pcpi_conflict = r_conflict;
`endif
endmodule

// File: tb/tb_pcpi_hub.sv
// Directed bench for pcpi_hub: one task per scenario, expected values computed by hand.
module tb_pcpi_hub;
   localparam int NS = 2;
   localparam int TO = 16;
   localparam logic [31:0] INSN_DIVU = {7'b0000001, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011};
   localparam logic [31:0] INSN_REM  = {7'b0000001, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011};
   localparam logic [31:0] INSN_DIV  = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011};
   localparam logic [31:0] INSN_ADD  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pcpi_hub_if #(.NUM_SLAVES(NS)) bus();
   pcpi_hub #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_slaves;
      bus.s_wr    = 2'b00;
      bus.s_rd    = 64'd0;
      bus.s_wait  = 2'b00;
      bus.s_ready = 2'b00;
   endtask

   task automatic request(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = insn;
      bus.pcpi_rs1   = rs1;
      bus.pcpi_rs2   = rs2;
   endtask

   task automatic test_reset;
      bus.pcpi_valid = 1'b0;
      bus.pcpi_insn  = 32'd0;
      bus.pcpi_rs1   = 32'd0;
      bus.pcpi_rs2   = 32'd0;
      clear_slaves();
      resetn = 1'b0;
      cyc();
      cyc();
      checks++;
      if ({bus.s_valid, bus.pcpi_wr, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000",
                  {bus.s_valid, bus.pcpi_wr, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout});
      end
      checks++;
      if ({bus.pcpi_rd, bus.s_insn, bus.s_rs1, bus.s_rs2} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data got rd=%h insn=%h rs1=%h rs2=%h want all 0",
                  bus.pcpi_rd, bus.s_insn, bus.s_rs1, bus.s_rs2);
      end
      resetn = 1'b1;
      cyc();
   endtask

   task automatic test_divu;
      request(INSN_DIVU, 32'd100, 32'd7);
      cyc();
      checks++;
      if ({bus.s_valid, bus.s_insn, bus.s_rs1, bus.s_rs2} !== {1'b1, INSN_DIVU, 32'd100, 32'd7}) begin
         errors++;
         $display("FAIL divu_dispatch got v=%b insn=%h rs1=%h rs2=%h want v=1 insn=%h rs1=64 rs2=7",
                  bus.s_valid, bus.s_insn, bus.s_rs1, bus.s_rs2, INSN_DIVU);
      end
      bus.pcpi_rs1 = 32'hDEADBEEF;
      bus.s_wait   = 2'b01;
      cyc();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.pcpi_wait, bus.s_valid, bus.pcpi_ready, bus.s_rs1} !== {1'b1, 1'b1, 1'b0, 32'd100}) begin
            errors++;
            $display("FAIL divu_busy[%0d] got wait=%b sv=%b rdy=%b rs1=%h want 1 1 0 00000064",
                     i, bus.pcpi_wait, bus.s_valid, bus.pcpi_ready, bus.s_rs1);
         end
         if (i == 1) bus.s_wait = 2'b00;
         cyc();
      end
      bus.s_ready = 2'b01;
      bus.s_wr    = 2'b01;
      bus.s_rd    = {32'h0, 32'h0000000E};
      cyc();
      clear_slaves();
      checks++;
      if ({bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd, bus.s_valid, bus.pcpi_wait} !==
          {1'b1, 1'b1, 32'h0000000E, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL divu_respond got rdy=%b wr=%b rd=%h sv=%b wait=%b want 1 1 0000000e 0 0",
                  bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd, bus.s_valid, bus.pcpi_wait);
      end
      bus.pcpi_valid = 1'b0;
      cyc();
      checks++;
      if ({bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd, bus.s_rs1} !== {1'b0, 1'b0, 32'h0000000E, 32'd100}) begin
         errors++;
         $display("FAIL divu_after got rdy=%b wr=%b rd=%h rs1=%h want 0 0 0000000e 00000064",
                  bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd, bus.s_rs1);
      end
      cyc();
   endtask

   task automatic test_back_to_back;
      request(INSN_REM, 32'hFFFFFFF9, 32'd2);
      cyc();
      bus.s_wait = 2'b01;
      cyc();
      bus.s_ready = 2'b01;
      bus.s_wr    = 2'b01;
      bus.s_rd    = {32'h0, 32'hFFFFFFFF};
      bus.s_wait  = 2'b00;
      cyc();
      clear_slaves();
      checks++;
      if ({bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd} !== {1'b1, 1'b1, 32'hFFFFFFFF}) begin
         errors++;
         $display("FAIL rem_respond got rdy=%b wr=%b rd=%h want 1 1 ffffffff",
                  bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd);
      end
      request(INSN_DIV, 32'd5, 32'd0);
      cyc();
      checks++;
      if ({bus.s_valid, bus.s_rs2, bus.pcpi_ready} !== {1'b0, 32'd2, 1'b0}) begin
         errors++;
         $display("FAIL b2b_gap got sv=%b rs2=%h rdy=%b want 0 00000002 0", bus.s_valid, bus.s_rs2, bus.pcpi_ready);
      end
      cyc();
      checks++;
      if ({bus.s_valid, bus.s_rs2} !== {1'b0, 32'd2}) begin
         errors++;
         $display("FAIL b2b_idle got sv=%b rs2=%h want 0 00000002", bus.s_valid, bus.s_rs2);
      end
      cyc();
      checks++;
      if ({bus.s_valid, bus.s_insn, bus.s_rs2} !== {1'b1, INSN_DIV, 32'd0}) begin
         errors++;
         $display("FAIL b2b_accept got sv=%b insn=%h rs2=%h want 1 %h 00000000",
                  bus.s_valid, bus.s_insn, bus.s_rs2, INSN_DIV);
      end
      bus.pcpi_valid = 1'b0;
      bus.s_ready = 2'b01;
      bus.s_wr    = 2'b01;
      bus.s_rd    = {32'h0, 32'hFFFFFFFF};
      cyc();
      clear_slaves();
      checks++;
      if ({bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd} !== {1'b1, 1'b1, 32'hFFFFFFFF}) begin
         errors++;
         $display("FAIL div0_respond got rdy=%b wr=%b rd=%h want 1 1 ffffffff",
                  bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd);
      end
      cyc();
      cyc();
   endtask

   task automatic test_timeout;
      int  n_to;
      logic seen_other;
      n_to = -1;
      seen_other = 1'b0;
      request(INSN_ADD, 32'd1, 32'd2);
      cyc();
      for (int n = 1; n <= 40; n++) begin
         cyc();
         seen_other = seen_other | bus.pcpi_wait | bus.pcpi_ready | bus.pcpi_wr;
         if (bus.pcpi_timeout) begin
            n_to = n;
            break;
         end
      end
      checks++;
      if (n_to != TO) begin
         errors++;
         $display("FAIL timeout_delay got %0d want %0d", n_to, TO);
      end
      checks++;
      if ({bus.s_valid, seen_other} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_side got sv=%b other=%b want 0 0", bus.s_valid, seen_other);
      end
      bus.pcpi_valid = 1'b0;
      cyc();
      checks++;
      if ({bus.pcpi_timeout, bus.s_valid, bus.pcpi_ready} !== 3'b000) begin
         errors++;
         $display("FAIL timeout_pulse got to=%b sv=%b rdy=%b want 000", bus.pcpi_timeout, bus.s_valid, bus.pcpi_ready);
      end
      cyc();
   endtask

   task automatic test_conflict;
      request(INSN_DIVU, 32'd9, 32'd3);
      cyc();
      bus.pcpi_valid = 1'b0;
      bus.s_ready = 2'b11;
      bus.s_wr    = 2'b10;
      bus.s_rd    = {32'h5555FFFF, 32'hAAAA0000};
      cyc();
      clear_slaves();
      checks++;
      if ({bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd} !== {1'b1, 1'b0, 32'hAAAA0000}) begin
         errors++;
         $display("FAIL conflict_lowest got rdy=%b wr=%b rd=%h want 1 0 aaaa0000",
                  bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd);
      end
`ifdef PCPI_HUB_CONFLICT_CHK_EN
      checks++;
      if (bus.pcpi_conflict !== 1'b1) begin
         errors++;
         $display("FAIL conflict_flag got %b want 1", bus.pcpi_conflict);
      end
`endif
      cyc();
`ifdef PCPI_HUB_CONFLICT_CHK_EN
      checks++;
      if (bus.pcpi_conflict !== 1'b0) begin
         errors++;
         $display("FAIL conflict_clear got %b want 0", bus.pcpi_conflict);
      end
`endif
      cyc();
      request(INSN_DIVU, 32'd9, 32'd3);
      cyc();
      bus.pcpi_valid = 1'b0;
      bus.s_ready = 2'b10;
      bus.s_wr    = 2'b10;
      bus.s_rd    = {32'h12345678, 32'hAAAA0000};
      cyc();
      clear_slaves();
      checks++;
      if ({bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd} !== {1'b1, 1'b1, 32'h12345678}) begin
         errors++;
         $display("FAIL slave1_only got rdy=%b wr=%b rd=%h want 1 1 12345678",
                  bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd);
      end
      cyc();
      cyc();
   endtask

   task automatic test_reset_mid;
      logic stray;
      stray = 1'b0;
      request(INSN_DIVU, 32'd1000, 32'd10);
      cyc();
      bus.s_wait = 2'b01;
      cyc();
      checks++;
      if (bus.pcpi_wait !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got wait=%b want 1", bus.pcpi_wait);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({bus.s_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout, bus.pcpi_wr, bus.pcpi_rd, bus.s_rs1} !==
          {5'b00000, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL mid_async got sv=%b wait=%b rdy=%b to=%b wr=%b rd=%h rs1=%h want all 0",
                  bus.s_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout, bus.pcpi_wr, bus.pcpi_rd, bus.s_rs1);
      end
      cyc();
      resetn = 1'b1;
      bus.pcpi_valid = 1'b0;
      clear_slaves();
      bus.s_ready = 2'b01;
      bus.s_wr    = 2'b01;
      for (int i = 0; i < 20; i++) begin
         cyc();
         stray = stray | bus.pcpi_ready | bus.pcpi_timeout | bus.s_valid;
      end
      checks++;
      if (stray !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_pulse got %b want 0", stray);
      end
      clear_slaves();
      request(INSN_DIVU, 32'd1000, 32'd10);
      cyc();
      bus.pcpi_valid = 1'b0;
      bus.s_ready = 2'b01;
      bus.s_wr    = 2'b01;
      bus.s_rd    = {32'h0, 32'h00000064};
      cyc();
      clear_slaves();
      checks++;
      if ({bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd} !== {1'b1, 1'b1, 32'h00000064}) begin
         errors++;
         $display("FAIL mid_recover got rdy=%b wr=%b rd=%h want 1 1 00000064",
                  bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_rd);
      end
      cyc();
      cyc();
   endtask

   initial begin
      test_reset();
      test_divu();
      test_back_to_back();
      test_timeout();
      test_conflict();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
